// File: rtl/regfile_param.sv
// Parametrised register file with two combinational read ports, a sequential
// clear engine (one register per cycle), optional zero register and write bypass.
module regfile_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_register,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] Read_register1,
  input  logic [ADDR_W-1:0] Read_register2,
  input  logic              clear_req,
  output logic [WIDTH-1:0]  rs1,
  output logic [WIDTH-1:0]  rs2,
  output logic              busy
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
  logic [WIDTH-1:0]  regs [NREG];
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_CMP);
  endfunction

  function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign busy  = (state == CLEAR);
  assign wr_en = RegWrite && !rst && (state == IDLE) &&
                 addr_in_range(Write_register) && !addr_is_zero_reg(Write_register);

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    if (state == IDLE) begin
      if (clear_req) begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    end else begin
      if (clr_ptr == LAST_ADDR) begin
        state_next = IDLE;
      end else begin
        clr_ptr_next = clr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Storage is only ever zeroed by the clear walk, never directly by rst.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      regs[clr_ptr] <= '0;
    end else if (wr_en) begin
      regs[Write_register] <= write_data;
    end
  end

  assign rd_addr[0] = Read_register1;
  assign rd_addr[1] = Read_register2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (!busy && addr_in_range(rd_addr[p]) && !addr_is_zero_reg(rd_addr[p])) begin
        if ((BYPASS != 0) && wr_en && (Write_register == rd_addr[p])) begin
          rd_data[p] = write_data;
        end else begin
          rd_data[p] = regs[rd_addr[p]];
        end
      end
    end
  end

  assign rs1 = rd_data[0];
  assign rs2 = rd_data[1];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and
// are checked against a countdown/array reference model.
module tb_regfile_param;

  localparam int NI = 3;
  localparam int P_W [NI] = '{4, 4, 8};
  localparam int P_D [NI] = '{4, 3, 8};
  localparam int P_A [NI] = '{2, 2, 3};
  localparam int P_Z [NI] = '{0, 1, 0};
  localparam int P_B [NI] = '{1, 0, 1};

  logic       clk;
  logic       rst, we, clr;
  logic [2:0] wa, ra1, ra2;
  logic [7:0] wd;

  logic [3:0] rs1_0, rs2_0, rs1_1, rs2_1;
  logic [7:0] rs1_2, rs2_2;
  logic       busy_0, busy_1, busy_2;

  logic [31:0] got_rs1 [NI];
  logic [31:0] got_rs2 [NI];
  logic        got_busy [NI];

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // reference model: registers as plain ints, busy as a remaining-cycle count
  int unsigned mreg [NI][8];
  int          cnt  [NI];

  // ---------------- clock / DUTs ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_param #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .RegWrite(we), .Write_register(wa[1:0]), .write_data(wd[3:0]),
    .Read_register1(ra1[1:0]), .Read_register2(ra2[1:0]), .clear_req(clr),
    .rs1(rs1_0), .rs2(rs2_0), .busy(busy_0));

  regfile_param #(.WIDTH(4), .DEPTH(3), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .RegWrite(we), .Write_register(wa[1:0]), .write_data(wd[3:0]),
    .Read_register1(ra1[1:0]), .Read_register2(ra2[1:0]), .clear_req(clr),
    .rs1(rs1_1), .rs2(rs2_1), .busy(busy_1));

  regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .RegWrite(we), .Write_register(wa), .write_data(wd),
    .Read_register1(ra1), .Read_register2(ra2), .clear_req(clr),
    .rs1(rs1_2), .rs2(rs2_2), .busy(busy_2));

  assign got_rs1[0] = 32'(rs1_0);
  assign got_rs2[0] = 32'(rs2_0);
  assign got_rs1[1] = 32'(rs1_1);
  assign got_rs2[1] = 32'(rs2_1);
  assign got_rs1[2] = 32'(rs1_2);
  assign got_rs2[2] = 32'(rs2_2);
  assign got_busy[0] = busy_0;
  assign got_busy[1] = busy_1;
  assign got_busy[2] = busy_2;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int msk(input int bits);
    return (1 << bits) - 1;
  endfunction

  function automatic bit write_lands(input int i);
    int aw;
    aw = int'(wa) & msk(P_A[i]);
    return we && !rst && cnt[i] == 0 && aw < P_D[i] && !(P_Z[i] != 0 && aw == 0);
  endfunction

  function automatic logic [31:0] exp_read(input int i, input int a_full);
    int a;
    a = a_full & msk(P_A[i]);
    if (cnt[i] > 0) return 0;
    if (a >= P_D[i]) return 0;
    if (P_Z[i] != 0 && a == 0) return 0;
    if (P_B[i] != 0 && write_lands(i) && (int'(wa) & msk(P_A[i])) == a)
      return 32'(int'(wd) & msk(P_W[i]));
    return 32'(mreg[i][a]);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        cnt[i] = P_D[i];
      end else if (cnt[i] > 0) begin
        mreg[i][P_D[i] - cnt[i]] = 0;
        cnt[i]--;
      end else begin
        if (write_lands(i))
          mreg[i][int'(wa) & msk(P_A[i])] = int'(wd) & msk(P_W[i]);
        if (clr) cnt[i] = P_D[i];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input int a, input int d,
                      input int r1, input int r2, input logic c);
    @(negedge clk);
    rst = r; we = w; clr = c;
    wa = 3'(a); wd = 8'(d); ra1 = 3'(r1); ra2 = 3'(r2);
    #2;
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d_busy", i), 32'(got_busy[i]), 32'(cnt[i] > 0));
        check($sformatf("u%0d_rs1", i), got_rs1[i], exp_read(i, r1));
        check($sformatf("u%0d_rs2", i), got_rs2[i], exp_read(i, r2));
      end
    end
    @(posedge clk);
    model_edge();
    if (r) armed = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(0, 0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 0; we = 0; clr = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      for (int j = 0; j < 8; j++) mreg[i][j] = 0;
    end

    // reset pulse, then walk through the clear and read every address
    step(1, 0, 0, 0, 0, 0, 0);
    idle(8);
    for (int a = 0; a < 8; a += 2) step(0, 0, 0, 0, a, a + 1, 0);

    // plain writes and reads
    step(0, 1, 1, 8'hA, 0, 0, 0);
    step(0, 1, 2, 8'h5, 0, 0, 0);
    step(0, 1, 3, 8'hF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 2, 2, 0);

    // same-cycle write/read of r2 exercises bypass (u0, u2) vs none (u1)
    step(0, 1, 2, 8'hC, 2, 2, 0);
    step(0, 0, 0, 0, 2, 1, 0);

    // clear together with a write, then rst at the second clear cycle
    step(0, 1, 0, 8'h7, 0, 0, 1);
    step(0, 1, 1, 8'h3, 0, 1, 0);
    step(1, 1, 2, 8'h4, 2, 0, 1);
    idle(9);
    for (int a = 0; a < 8; a += 2) step(0, 0, 0, 0, a, a + 1, 0);

    // zero register and out-of-range writes
    step(0, 1, 0, 8'h9, 0, 0, 0);
    step(0, 1, 3, 8'h6, 3, 0, 0);
    step(0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 1, 2, 0);

    // wide instance top addresses, then a clear
    step(0, 1, 7, 8'hA5, 7, 4, 0);
    step(0, 1, 4, 8'h3C, 7, 4, 0);
    step(0, 0, 0, 0, 7, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(9);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 4x4 register bank: configurable data width and register count.
- Two fully addressed combinational read ports replace the external 2:1 mux pairing.
- Adds synchronous reset, a sequential clear engine (one register per cycle) with a busy flag, optional hard-wired zero register and optional write-to-read bypass.
- Sits between the ALU data path (write side) and the operand LEDs/consumers (rs1/rs2).

Parameters:
- WIDTH, 4: data bits per register.
- DEPTH, 4: number of registers; 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 2: width of all register-select ports.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a read of the address being written this cycle returns write_data.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  1  write enable, sampled on clk rising edge.
- Write_register  in  ADDR_W  write address.
- write_data  in  WIDTH  data to write.
- Read_register1  in  ADDR_W  read address, port 1.
- Read_register2  in  ADDR_W  read address, port 2.
- clear_req  in  1  single-cycle request to zero all registers.
- rs1  out  WIDTH  read data, port 1 (combinational).
- rs2  out  WIDTH  read data, port 2 (combinational).
- busy  out  1  high while the clear engine runs.

Behaviour:
- FSM states: IDLE and CLEAR. A clear pointer clr_ptr is ADDR_W bits wide.
- rst (any state): next state is CLEAR, clr_ptr <= 0. Register contents are not zeroed directly; the clear sequence zeroes them.
- rst asserted mid-CLEAR restarts the sequence from address 0.
- CLEAR, each cycle:
  - reg[clr_ptr] <= 0 and clr_ptr increments.
  - When clr_ptr == DEPTH-1, that register is zeroed and next state is IDLE.
  - A clear therefore occupies exactly DEPTH cycles.
- IDLE: clear_req=1 -> next state CLEAR, clr_ptr <= 0. clear_req is ignored in CLEAR; it does not extend or restart the sequence.
- busy = (state == CLEAR). It goes high the cycle after rst/clear_req is sampled and is high for DEPTH cycles.
- busy reset value: 1 after reset deasserts, until the clear completes.
- Writes (IDLE only): RegWrite=1 and Write_register < DEPTH -> reg[Write_register] <= write_data at the clock edge; one write per cycle.
- Writes are dropped in these cases:
  - Write_register >= DEPTH.
  - ZERO_REG=1 and Write_register == 0.
  - State is CLEAR, or rst is high.
- In IDLE, clear_req and RegWrite in the same cycle: the write commits on that edge, then the clear sequence erases it.
- Reads (combinational, zero latency), for each port p with address a:
  - busy=1 -> rs_p = 0.
  - a >= DEPTH -> rs_p = 0.
  - ZERO_REG=1 and a == 0 -> rs_p = 0.
  - BYPASS=1, RegWrite=1, Write_register == a, and the write is not dropped -> rs_p = write_data.
  - Otherwise rs_p = reg[a].
- Both read ports may address the same register; both return the same value.
- Outputs after reset: rs1 = rs2 = 0 and busy = 1 for DEPTH cycles. Thereafter every register reads 0 until written.
- No X may propagate to outputs after the first clear completes.

Test Plan:
- Reset, DEPTH=4: pulse rst 1 cycle -> busy high exactly 4 cycles, rs1=rs2=0 throughout; then all 4 addresses read 0.
- Writes and reads: write 0xA->r1, 0x5->r2, 0xF->r3 on 3 cycles; read (1,3) -> rs1=0xA, rs2=0xF; read (2,2) -> rs1=rs2=0x5.
- Bypass: BYPASS=1, write 0xC->r2 with Read_register1=2 in the same cycle -> rs1=0xC before the edge. BYPASS=0 -> rs1 shows the old value 0x5 until after the edge.
- Clear during writes: clear_req with RegWrite of 0x7->r0 in the same IDLE cycle -> busy high 4 cycles, RegWrite ignored while busy, afterwards r0..r3 all read 0. Assert rst at clear cycle 2 -> busy lasts 4 more cycles from restart.
- ZERO_REG=1: write 0x9->r0 -> rs1(0)=0. DEPTH=3, ADDR_W=2: write 0x6->addr 3 -> dropped, read addr 3 -> 0, r0..r2 unchanged.
- Width scaling: WIDTH=8, DEPTH=8, ADDR_W=3: write 0xA5->r7, 0x3C->r4 -> reads return 0xA5/0x3C; clear -> busy high 8 cycles.
